timer_countdown_bcd: RTL and testbench

- Parametrised successor to the MM:SS irrigation countdown timer. Holds a four-digit BCD count (tens of minutes, units of minutes, tens of seconds, units of seconds) and decrements it once per second.
- The one-second tick comes from an internal prescaler, so there is no gated or ripple clock.
- Adds run/pause/done state, auto-reload mode, preset clamping, a done pulse and an internal 7-segment scan driver.
- Sits between the irrigation controller (start/load commands, done consumer) and the board display.

---
 rtl/timer_countdown_bcd.sv | 195 +++++++++++++++++++
 tb/tb_timer_countdown_bcd.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_countdown_bcd.sv
// rtl/timer_countdown_bcd.sv - MM:SS BCD countdown timer with prescaled tick and 7-segment scan
module timer_countdown_bcd #(
  parameter int TICK_DIV = 50000000,
  parameter int SCAN_DIV = 50000,
  parameter int MAX_DM   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] preset_dm,
  input  logic [3:0] preset_um,
  input  logic [3:0] preset_ds,
  input  logic [3:0] preset_us,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       auto_reload,
  output logic [3:0] dm,
  output logic [3:0] um,
  output logic [3:0] ds,
  output logic [3:0] us,
  output logic       running,
  output logic       done,
  output logic [7:0] seg,
  output logic [3:0] digit_en
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [3:0]    MAX_DM_DIG = 4'(MAX_DM);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} stateType;

  stateType      state;
  logic [TW-1:0] presc;
  logic [3:0]    storedDm, storedUm, storedDs, storedUs;
  logic          reloadPending;
  logic [SW-1:0] scanCnt;
  logic [1:0]    scanIdx;

  logic [3:0] clampDm, clampUm, clampDs, clampUs;
  logic [3:0] decDm, decUm, decDs, decUs;
  logic       tick, countZero, countOne, storedZero;
  logic [3:0] selDigit;
  logic [6:0] segBits;

  assign tick       = (state == RUN) && (presc == TICK_LAST);
  assign countZero  = ({dm, um, ds, us} == 16'h0000);
  assign countOne   = ({dm, um, ds, us} == 16'h0001);
  assign storedZero = ({storedDm, storedUm, storedDs, storedUs} == 16'h0000);

  // Limit each preset digit to its legal range before it reaches the count.
  always_comb begin
    clampDm = (preset_dm > MAX_DM_DIG) ? MAX_DM_DIG : preset_dm;
    clampUm = (preset_um > 4'd9) ? 4'd9 : preset_um;
    clampDs = (preset_ds > 4'd5) ? 4'd5 : preset_ds;
    clampUs = (preset_us > 4'd9) ? 4'd9 : preset_us;
  end

  // One-second BCD decrement with borrow rippling from seconds up to tens of minutes.
  always_comb begin
    decUs = (us == 4'd0) ? 4'd9 : us - 4'd1;
    decDs = ds;
    decUm = um;
    decDm = dm;
    if (us == 4'd0) begin
      decDs = (ds == 4'd0) ? 4'd5 : ds - 4'd1;
      if (ds == 4'd0) begin
        decUm = (um == 4'd0) ? 4'd9 : um - 4'd1;
        if (um == 4'd0) begin
          decDm = dm - 4'd1;
        end
      end
    end
  end

  // Timer FSM: command priority clear > load > pause > start, then prescaled decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      running       <= 1'b0;
      done          <= 1'b0;
      presc         <= '0;
      reloadPending <= 1'b0;
      {dm, um, ds, us} <= 16'h0000;
      {storedDm, storedUm, storedDs, storedUs} <= 16'h0000;
    end else begin
      done          <= 1'b0;
      reloadPending <= 1'b0;
      if (clear) begin
        state   <= IDLE;
        running <= 1'b0;
        presc   <= '0;
        {dm, um, ds, us} <= 16'h0000;
      end else if (load) begin
        {dm, um, ds, us} <= {clampDm, clampUm, clampDs, clampUs};
        {storedDm, storedUm, storedDs, storedUs} <= {clampDm, clampUm, clampDs, clampUs};
        presc <= '0;
        if (state != RUN) begin
          state   <= IDLE;
          running <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (start && !countZero) begin
              state   <= RUN;
              running <= 1'b1;
              presc   <= '0;
            end
          end
          PAUSE: begin
            if (start && !countZero) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (pause) begin
              // The prescaler holds its value so a resume continues the current second.
              state   <= PAUSE;
              running <= 1'b0;
              if (reloadPending) begin
                {dm, um, ds, us} <= {storedDm, storedUm, storedDs, storedUs};
              end
            end else begin
              presc <= tick ? '0 : presc + 1'b1;
              if (reloadPending) begin
                {dm, um, ds, us} <= {storedDm, storedUm, storedDs, storedUs};
              end else if (tick && !countZero) begin
                if (countOne) begin
                  // Expiry: show 00:00 for one cycle alongside the done pulse.
                  {dm, um, ds, us} <= 16'h0000;
                  done <= 1'b1;
                  if (auto_reload && !storedZero) begin
                    reloadPending <= 1'b1;
                  end else begin
                    state   <= DONE;
                    running <= 1'b0;
                  end
                end else begin
                  {dm, um, ds, us} <= {decDm, decUm, decDs, decUs};
                end
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Free-running digit scan; enable rotates in step with the index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scanCnt  <= '0;
      scanIdx  <= 2'd0;
      digit_en <= 4'b0001;
    end else if (scanCnt == SCAN_LAST) begin
      scanCnt  <= '0;
      scanIdx  <= scanIdx + 2'd1;
      digit_en <= {digit_en[2:0], digit_en[3]};
    end else begin
      scanCnt <= scanCnt + 1'b1;
    end
  end

  // Segment decode of the selected digit; dp marks the minute/second separator.
  always_comb begin
    case (scanIdx)
      2'd0:    selDigit = us;
      2'd1:    selDigit = ds;
      2'd2:    selDigit = um;
      default: selDigit = dm;
    endcase
    case (selDigit)
      4'd0:    segBits = 7'h3F;
      4'd1:    segBits = 7'h06;
      4'd2:    segBits = 7'h5B;
      4'd3:    segBits = 7'h4F;
      4'd4:    segBits = 7'h66;
      4'd5:    segBits = 7'h6D;
      4'd6:    segBits = 7'h7D;
      4'd7:    segBits = 7'h07;
      4'd8:    segBits = 7'h7F;
      4'd9:    segBits = 7'h6F;
      default: segBits = 7'h00;
    endcase
    seg = {(scanIdx == 2'd2), segBits};
  end

endmodule

// File: tb/tb_timer_countdown_bcd.sv
// tb/tb_timer_countdown_bcd.sv - self-checking bench for timer_countdown_bcd
module tb_timer_countdown_bcd;

  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;
  localparam int MAX_DM   = 5;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0, auto_reload = 1'b0;
  logic [3:0] preset_dm = 4'd0, preset_um = 4'd0, preset_ds = 4'd0, preset_us = 4'd0;
  logic [3:0] dm, um, ds, us;
  logic running, done;
  logic [7:0] seg;
  logic [3:0] digit_en;

  timer_countdown_bcd #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .MAX_DM(MAX_DM)) dut (
    .clk(clk), .rst_n(rst_n), .load(load),
    .preset_dm(preset_dm), .preset_um(preset_um), .preset_ds(preset_ds), .preset_us(preset_us),
    .start(start), .pause(pause), .clear(clear), .auto_reload(auto_reload),
    .dm(dm), .um(um), .ds(ds), .us(us),
    .running(running), .done(done), .seg(seg), .digit_en(digit_en)
  );

  always #5 clk = ~clk;

  int passCnt = 0;
  int checkCnt = 0;
  int edgeCnt = 0;
  bit checkEn = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Model: count held as total seconds, time within the second as a cycle phase.
  typedef struct packed {
    int secs;
    int preset;
    int mode;
    int phase;
    int scan;
    bit done;
    bit reload;
  } model_t;

  model_t m = '0;

  logic [6:0] segTab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic int clampSecs(input int pdm, input int pum, input int pds, input int pus);
    int a, b, c, d;
    a = (pdm > MAX_DM) ? MAX_DM : pdm;
    b = (pum > 9) ? 9 : pum;
    c = (pds > 5) ? 5 : pds;
    d = (pus > 9) ? 9 : pus;
    return (a * 10 + b) * 60 + c * 10 + d;
  endfunction

  function automatic logic [15:0] bcdOf(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  function automatic model_t modelNext(input model_t c);
    model_t n;
    bit pend;
    n = c;
    pend = c.reload;
    n.scan = c.scan + 1;
    n.done = 1'b0;
    n.reload = 1'b0;
    if (clear) begin
      n.secs = 0;
      n.phase = 0;
      n.mode = M_IDLE;
    end else if (load) begin
      n.secs = clampSecs(int'(preset_dm), int'(preset_um), int'(preset_ds), int'(preset_us));
      n.preset = n.secs;
      n.phase = 0;
      if (c.mode != M_RUN) n.mode = M_IDLE;
    end else if (c.mode == M_RUN && pause) begin
      n.mode = M_PAUSE;
      if (pend) n.secs = c.preset;
    end else if (start && (c.mode == M_IDLE || c.mode == M_PAUSE) && c.secs != 0) begin
      if (c.mode == M_IDLE) n.phase = 0;
      n.mode = M_RUN;
    end else if (c.mode == M_RUN) begin
      if (pend) n.secs = c.preset;
      if (c.phase == TICK_DIV - 1) begin
        n.phase = 0;
        if (c.secs > 0 && !pend) begin
          n.secs = c.secs - 1;
          if (n.secs == 0) begin
            n.done = 1'b1;
            if (auto_reload && c.preset != 0) n.reload = 1'b1;
            else n.mode = M_DONE;
          end
        end
      end else begin
        n.phase = c.phase + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else m <= modelNext(m);
  end

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (checkEn && rst_n) begin
      int idx;
      logic [15:0] cnt;
      logic [3:0] dig;
      idx = (m.scan / SCAN_DIV) % 4;
      cnt = bcdOf(m.secs);
      dig = cnt[idx*4 +: 4];
      chk("model_count", 32'({dm, um, ds, us}), 32'(cnt));
      chk("model_running", 32'(running), 32'(m.mode == M_RUN));
      chk("model_done", 32'(done), 32'(m.done));
      chk("model_digit_en", 32'(digit_en), 32'(1 << idx));
      chk("model_seg", 32'(seg), 32'({idx == 2, segTab[dig]}));
    end
  end

  task automatic doLoad(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    preset_dm = a; preset_um = b; preset_ds = c; preset_us = d;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic doStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic doClear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int startEdge, nDone, doneAt, notRun;
    logic [24:0] doneMask;
    logic [15:0] c4, c8, c9;
    logic [3:0] expEn [9];
    expEn = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_count", 32'({dm, um, ds, us}), 32'h0);
    chk("reset_running", 32'(running), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_digit_en", 32'(digit_en), 32'h1);
    chk("reset_seg", 32'(seg), 32'h3F);
    rst_n = 1'b1;
    checkEn = 1'b1;
    @(negedge clk);

    // Expiry from 00:03
    doLoad(4'd0, 4'd0, 4'd0, 4'd3);
    doStart();
    startEdge = edgeCnt;
    nDone = 0;
    doneAt = -1;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        nDone++;
        if (doneAt < 0) doneAt = edgeCnt - startEdge;
      end
      @(negedge clk);
    end
    chk("expire_done_count", 32'(nDone), 32'd1);
    chk("expire_latency", 32'(doneAt), 32'd12);
    chk("expire_count", 32'({dm, um, ds, us}), 32'h0);
    chk("expire_running", 32'(running), 32'h0);
    doStart();
    chk("done_ignores_start", 32'(running), 32'h0);

    // Borrow chain
    doLoad(4'd1, 4'd0, 4'd0, 4'd0);
    doStart();
    repeat (3) @(negedge clk);
    chk("borrow_before_tick", 32'({dm, um, ds, us}), 32'h1000);
    @(negedge clk);
    chk("borrow_1000", 32'({dm, um, ds, us}), 32'h0959);
    doLoad(4'd0, 4'd1, 4'd0, 4'd0);
    repeat (4) @(negedge clk);
    chk("borrow_0100", 32'({dm, um, ds, us}), 32'h0059);
    chk("borrow_running", 32'(running), 32'h1);
    doClear();

    // Pause at prescaler 2, hold, resume
    doLoad(4'd0, 4'd0, 4'd3, 4'd0);
    doStart();
    repeat (2) @(negedge clk);
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
    chk("pause_running", 32'(running), 32'h0);
    repeat (20) @(negedge clk);
    chk("pause_hold", 32'({dm, um, ds, us}), 32'h0030);
    doStart();
    chk("resume_running", 32'(running), 32'h1);
    chk("resume_count0", 32'({dm, um, ds, us}), 32'h0030);
    @(negedge clk);
    chk("resume_count1", 32'({dm, um, ds, us}), 32'h0030);
    @(negedge clk);
    chk("resume_tick", 32'({dm, um, ds, us}), 32'h0029);
    doClear();

    // Auto-reload with preset 00:02
    auto_reload = 1'b1;
    doLoad(4'd0, 4'd0, 4'd0, 4'd2);
    doStart();
    doneMask = '0;
    notRun = 0;
    c4 = '0; c8 = '0; c9 = '0;
    for (int k = 0; k < 25; k++) begin
      if (done) doneMask[k] = 1'b1;
      if (!running) notRun++;
      if (k == 4) c4 = {dm, um, ds, us};
      if (k == 8) c8 = {dm, um, ds, us};
      if (k == 9) c9 = {dm, um, ds, us};
      @(negedge clk);
    end
    chk("reload_done_pattern", 32'(doneMask), 32'h1010100);
    chk("reload_running", 32'(notRun), 32'd0);
    chk("reload_c4", 32'(c4), 32'h0001);
    chk("reload_c8", 32'(c8), 32'h0000);
    chk("reload_c9", 32'(c9), 32'h0002);
    doClear();
    auto_reload = 1'b0;
    chk("reload_clear_running", 32'(running), 32'h0);
    chk("reload_clear_count", 32'({dm, um, ds, us}), 32'h0);

    // Clamping and priority
    doLoad(4'd8, 4'd10, 4'd7, 4'd12);
    chk("clamp", 32'({dm, um, ds, us}), 32'h5959);
    preset_dm = 4'd1; preset_um = 4'd2; preset_ds = 4'd3; preset_us = 4'd4;
    load = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    load = 1'b0;
    clear = 1'b0;
    chk("clear_over_load", 32'({dm, um, ds, us}), 32'h0);
    doStart();
    chk("start_zero_ignored", 32'(running), 32'h0);

    // Asynchronous reset mid-run, then scan sequence from reset
    doLoad(4'd0, 4'd0, 4'd1, 4'd0);
    doStart();
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'({dm, um, ds, us}), 32'h0);
    chk("async_rst_running", 32'(running), 32'h0);
    chk("async_rst_digit_en", 32'(digit_en), 32'h1);
    chk("async_rst_seg", 32'(seg), 32'h3F);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      chk("scan_digit_en", 32'(digit_en), 32'(expEn[k]));
      chk("scan_dp", 32'(seg[7]), 32'(expEn[k] == 4'b0100));
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
